// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding select and load-use stall generator for the 5-stage pipeline.
// Optional saturating stall counter enabled by defining FWD_STALL_CNT_EN.
module fwd_hazard_ctrl #(
   parameter int REG_AW      = 5,
   parameter int STALL_CNT_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              flush,
   output logic              stall,
   output logic              ex_bubble,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel
`ifdef FWD_STALL_CNT_EN
   ,
   output logic [STALL_CNT_W-1:0] stall_count
`endif
);

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_MEM = 2'b01;
   localparam logic [1:0] SEL_EX  = 2'b10;

   logic              ex_v;
   logic              ex_we;
   logic              ex_ld;
   logic [REG_AW-1:0] ex_rd;
   // The MEM shadow never needs the load flag: a MEM-stage load result is forwardable.
   logic              mem_v;
   logic              mem_we;
   logic [REG_AW-1:0] mem_rd;

   logic              hit_e1;
   logic              hit_e2;
   logic              hit_m1;
   logic              hit_m2;
   logic              load_use;
   logic              issue;
   logic [1:0]        sel_a;
   logic [1:0]        sel_b;

   function automatic logic producer_hit(
      input logic              v,
      input logic              we,
      input logic [REG_AW-1:0] rd,
      input logic [REG_AW-1:0] rs
   );
      return v && we && (rd != '0) && (rs == rd);
   endfunction

   function automatic logic [1:0] pick_sel(
      input logic rd_en,
      input logic hit_e,
      input logic hit_m,
      input logic e_is_load
   );
      logic [1:0] sel;
      sel = SEL_RF;
      if (rd_en) begin
         if (hit_e && !e_is_load) begin
            sel = SEL_EX;
         end else if (hit_m) begin
            sel = SEL_MEM;
         end
      end
      return sel;
   endfunction

   always_comb begin
      hit_e1   = producer_hit(ex_v, ex_we, ex_rd, id_rs1);
      hit_e2   = producer_hit(ex_v, ex_we, ex_rd, id_rs2);
      hit_m1   = producer_hit(mem_v, mem_we, mem_rd, id_rs1);
      hit_m2   = producer_hit(mem_v, mem_we, mem_rd, id_rs2);
      load_use = id_valid & ex_ld & ((id_use_rs1 & hit_e1) | (id_use_rs2 & hit_e2));
      stall    = load_use & ~flush;
      issue    = id_valid & ~flush & ~load_use;
      sel_a    = pick_sel(id_use_rs1, hit_e1, hit_m1, ex_ld);
      sel_b    = pick_sel(id_use_rs2, hit_e2, hit_m2, ex_ld);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_v      <= 1'b0;
         ex_we     <= 1'b0;
         ex_ld     <= 1'b0;
         ex_rd     <= '0;
         mem_v     <= 1'b0;
         mem_we    <= 1'b0;
         mem_rd    <= '0;
         fwd_a_sel <= SEL_RF;
         fwd_b_sel <= SEL_RF;
         ex_bubble <= 1'b0;
      end else begin
         mem_v  <= ex_v;
         mem_we <= ex_we;
         mem_rd <= ex_rd;
         if (issue) begin
            ex_v      <= 1'b1;
            ex_rd     <= id_rd;
            ex_we     <= id_reg_write;
            ex_ld     <= id_mem_read;
            fwd_a_sel <= sel_a;
            fwd_b_sel <= sel_b;
            ex_bubble <= 1'b0;
         end else begin
            ex_v      <= 1'b0;
            fwd_a_sel <= SEL_RF;
            fwd_b_sel <= SEL_RF;
            ex_bubble <= flush | stall;
         end
      end
   end

`ifdef FWD_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_count <= '0;
      end else if (stall && (stall_count != '1)) begin
         stall_count <= stall_count + STALL_CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed vector table, reset corner and random stimulus.
module tb_fwd_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_use_rs1;
   logic        id_use_rs2;
   logic [4:0]  id_rd;
   logic        id_reg_write;
   logic        id_mem_read;
   logic        flush;
   logic        stall;
   logic        ex_bubble;
   logic [1:0]  fwd_a_sel;
   logic [1:0]  fwd_b_sel;
`ifdef FWD_STALL_CNT_EN
   logic [31:0] stall_count;
`endif

   always #5 clk = ~clk;

   fwd_hazard_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_valid     (id_valid),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_use_rs1   (id_use_rs1),
      .id_use_rs2   (id_use_rs2),
      .id_rd        (id_rd),
      .id_reg_write (id_reg_write),
      .id_mem_read  (id_mem_read),
      .flush        (flush),
      .stall        (stall),
      .ex_bubble    (ex_bubble),
      .fwd_a_sel    (fwd_a_sel),
      .fwd_b_sel    (fwd_b_sel)
`ifdef FWD_STALL_CNT_EN
      ,
      .stall_count  (stall_count)
`endif
   );

   typedef struct {
      logic       v;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       we;
      logic       ld;
      logic       fl;
   } in_t;

   typedef struct {
      in_t        i;
      logic       e_stall;
      logic       e_bub;
      logic [1:0] e_a;
      logic [1:0] e_b;
   } vec_t;

   // Reference model: the two most recent issued instructions, index 0 = youngest (EX).
   typedef struct {
      bit       v;
      bit [4:0] rd;
      bit       we;
      bit       ld;
   } slot_t;

   slot_t       pipe [2];
   bit [1:0]    m_a;
   bit [1:0]    m_b;
   bit          m_bub;
   int unsigned m_cnt;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   function automatic in_t mk(input int v, input int rs1, input int rs2, input int u1, input int u2,
                              input int rd, input int we, input int ld, input int fl);
      in_t x;
      x.v   = 1'(v);
      x.rs1 = 5'(rs1);
      x.rs2 = 5'(rs2);
      x.u1  = 1'(u1);
      x.u2  = 1'(u2);
      x.rd  = 5'(rd);
      x.we  = 1'(we);
      x.ld  = 1'(ld);
      x.fl  = 1'(fl);
      return x;
   endfunction

   function automatic vec_t mkv(input in_t x, input int es, input int eb, input int ea, input int ebs);
      vec_t t;
      t.i       = x;
      t.e_stall = 1'(es);
      t.e_bub   = 1'(eb);
      t.e_a     = 2'(ea);
      t.e_b     = 2'(ebs);
      return t;
   endfunction

   function automatic bit [1:0] nearest(input bit used, input bit [4:0] rs, output bit haz);
      haz = 1'b0;
      if (!used || rs == 5'd0) return 2'b00;
      for (int age = 0; age < 2; age++) begin
         if (pipe[age].v && pipe[age].we && pipe[age].rd == rs) begin
            if (age == 0 && pipe[age].ld) begin
               haz = 1'b1;
               return 2'b00;
            end
            return (age == 0) ? 2'b10 : 2'b01;
         end
      end
      return 2'b00;
   endfunction

   task automatic model_reset();
      pipe[0] = '{1'b0, 5'd0, 1'b0, 1'b0};
      pipe[1] = '{1'b0, 5'd0, 1'b0, 1'b0};
      m_a     = 2'b00;
      m_b     = 2'b00;
      m_bub   = 1'b0;
      m_cnt   = 0;
   endtask

   task automatic model_eval(input in_t x, output bit st, output bit [1:0] a, output bit [1:0] b);
      bit h1, h2;
      a  = nearest(x.u1, x.rs1, h1);
      b  = nearest(x.u2, x.rs2, h2);
      st = x.v && (h1 || h2) && !x.fl;
   endtask

   task automatic model_commit(input in_t x, input bit st, input bit [1:0] a, input bit [1:0] b);
      bit issue;
      issue   = x.v && !x.fl && !st;
      pipe[1] = pipe[0];
      if (issue) pipe[0] = '{1'b1, x.rd, x.we, x.ld};
      else       pipe[0] = '{1'b0, 5'd0, 1'b0, 1'b0};
      m_a   = issue ? a : 2'b00;
      m_b   = issue ? b : 2'b00;
      m_bub = x.fl || st;
      if (st && m_cnt != 32'hFFFF_FFFF) m_cnt++;
   endtask

   task automatic drive(input in_t x);
      id_valid     = x.v;
      id_rs1       = x.rs1;
      id_rs2       = x.rs2;
      id_use_rs1   = x.u1;
      id_use_rs2   = x.u2;
      id_rd        = x.rd;
      id_reg_write = x.we;
      id_mem_read  = x.ld;
      flush        = x.fl;
   endtask

   // Called one time unit after a rising edge; leaves the bench at the same phase.
   task automatic cycle(input in_t x, input bit tbl, input bit es, input bit eb,
                        input bit [1:0] ea, input bit [1:0] ebs);
      bit       st;
      bit [1:0] a, b;
      drive(x);
      model_eval(x, st, a, b);
      @(negedge clk);
      chk("stall", 32'(stall), tbl ? 32'(es) : 32'(st));
      @(posedge clk);
      model_commit(x, st, a, b);
      #1;
      chk("ex_bubble", 32'(ex_bubble), tbl ? 32'(eb) : 32'(m_bub));
      chk("fwd_a_sel", 32'(fwd_a_sel), tbl ? 32'(ea) : 32'(m_a));
      chk("fwd_b_sel", 32'(fwd_b_sel), tbl ? 32'(ebs) : 32'(m_b));
`ifdef FWD_STALL_CNT_EN
      chk("stall_count", stall_count, m_cnt);
`endif
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      model_reset();
      #1;
      rst_n = 1'b1;
   endtask

   vec_t tbl [$];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   initial begin
      in_t      x;
      in_t      lw;
      in_t      add;

      // v, rs1, rs2, u1, u2, rd, we, ld, fl  ->  stall, bubble, a_sel, b_sel
      tbl.push_back(mkv(mk(1, 1, 2, 1, 1, 5, 1, 0, 0), 0, 0, 0, 0));
      tbl.push_back(mkv(mk(1, 5, 7, 1, 1, 6, 1, 0, 0), 0, 0, 2, 0));
      tbl.push_back(mkv(mk(1, 10, 11, 1, 1, 9, 1, 0, 0), 0, 0, 0, 0));
      tbl.push_back(mkv(mk(1, 1, 2, 1, 1, 5, 1, 0, 0), 0, 0, 0, 0));
      tbl.push_back(mkv(mk(1, 13, 14, 1, 1, 12, 1, 0, 0), 0, 0, 0, 0));
      tbl.push_back(mkv(mk(1, 1, 5, 1, 1, 8, 1, 0, 0), 0, 0, 0, 1));
      tbl.push_back(mkv(mk(1, 2, 0, 1, 0, 3, 1, 1, 0), 0, 0, 0, 0));
      tbl.push_back(mkv(mk(1, 3, 3, 1, 1, 4, 1, 0, 0), 1, 1, 0, 0));
      tbl.push_back(mkv(mk(1, 3, 3, 1, 1, 4, 1, 0, 0), 0, 0, 1, 1));
      tbl.push_back(mkv(mk(1, 2, 0, 1, 0, 3, 1, 1, 0), 0, 0, 0, 0));
      tbl.push_back(mkv(mk(1, 3, 3, 1, 1, 4, 1, 0, 1), 0, 1, 0, 0));
      tbl.push_back(mkv(mk(1, 1, 2, 1, 1, 0, 1, 0, 0), 0, 0, 0, 0));
      tbl.push_back(mkv(mk(1, 0, 0, 1, 1, 7, 1, 0, 0), 0, 0, 0, 0));
      tbl.push_back(mkv(mk(1, 1, 0, 1, 0, 0, 1, 1, 0), 0, 0, 0, 0));
      tbl.push_back(mkv(mk(1, 0, 0, 1, 1, 7, 1, 0, 0), 0, 0, 0, 0));
      tbl.push_back(mkv(mk(1, 1, 2, 1, 1, 5, 1, 0, 0), 0, 0, 0, 0));
      tbl.push_back(mkv(mk(1, 1, 2, 1, 1, 5, 1, 0, 0), 0, 0, 0, 0));
      tbl.push_back(mkv(mk(1, 5, 5, 1, 1, 9, 1, 0, 0), 0, 0, 2, 2));
      tbl.push_back(mkv(mk(1, 1, 0, 1, 0, 3, 1, 1, 0), 0, 0, 0, 0));
      tbl.push_back(mkv(mk(0, 3, 3, 1, 1, 4, 1, 0, 0), 0, 0, 0, 0));
      tbl.push_back(mkv(mk(1, 3, 0, 1, 0, 4, 1, 0, 0), 0, 0, 1, 0));
      tbl.push_back(mkv(mk(1, 1, 0, 1, 0, 3, 1, 1, 0), 0, 0, 0, 0));
      tbl.push_back(mkv(mk(1, 1, 3, 1, 1, 0, 0, 0, 0), 1, 1, 0, 0));
      tbl.push_back(mkv(mk(1, 1, 3, 1, 1, 0, 0, 0, 0), 0, 0, 0, 1));
      tbl.push_back(mkv(mk(1, 9, 0, 1, 0, 3, 1, 1, 0), 0, 0, 0, 0));
      tbl.push_back(mkv(mk(1, 3, 3, 0, 0, 6, 1, 0, 0), 0, 0, 0, 0));
      tbl.push_back(mkv(mk(1, 6, 3, 1, 0, 7, 1, 0, 0), 0, 0, 2, 0));

      do_reset();
      chk("reset_stall", 32'(stall), 32'd0);
      chk("reset_ex_bubble", 32'(ex_bubble), 32'd0);
      chk("reset_fwd_a_sel", 32'(fwd_a_sel), 32'd0);
      chk("reset_fwd_b_sel", 32'(fwd_b_sel), 32'd0);
`ifdef FWD_STALL_CNT_EN
      chk("reset_stall_count", stall_count, 32'd0);
`endif

      foreach (tbl[k]) begin
         cycle(tbl[k].i, 1'b1, tbl[k].e_stall, tbl[k].e_bub, tbl[k].e_a, tbl[k].e_b);
      end
`ifdef FWD_STALL_CNT_EN
      chk("table_stall_count", stall_count, 32'd2);
`endif

      // Reset arriving while a load-use stall is pending drops the load.
      do_reset();
      lw  = mk(1, 1, 0, 1, 0, 3, 1, 1, 0);
      add = mk(1, 3, 3, 1, 1, 4, 1, 0, 0);
      cycle(lw, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
      drive(add);
      @(negedge clk);
      chk("midrst_stall_before", 32'(stall), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      model_reset();
      #1;
      chk("midrst_stall_after", 32'(stall), 32'd0);
      chk("midrst_ex_bubble", 32'(ex_bubble), 32'd0);
      chk("midrst_fwd_a_sel", 32'(fwd_a_sel), 32'd0);
      chk("midrst_fwd_b_sel", 32'(fwd_b_sel), 32'd0);
      rst_n = 1'b1;
      cycle(add, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);

      // Random traffic over a small register window to provoke frequent hazards.
      do_reset();
      for (int n = 0; n < 500; n++) begin
         x.v   = ($urandom_range(0, 9) < 8);
         x.rs1 = 5'($urandom_range(0, 3));
         x.rs2 = 5'($urandom_range(0, 3));
         x.u1  = 1'($urandom_range(0, 1));
         x.u2  = 1'($urandom_range(0, 1));
         x.rd  = 5'($urandom_range(0, 3));
         x.we  = ($urandom_range(0, 3) != 0);
         x.ld  = ($urandom_range(0, 2) == 0);
         x.fl  = ($urandom_range(0, 9) == 0);
         cycle(x, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
